// File: rtl/lsu_subword_ctrl.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | lsu_subword_ctrl : byte/half/word load-store sequencer for word-only RAM   |
// | rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
module lsu_subword_ctrl #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_funct3,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_err,
   output logic              MemRead,
   output logic              MemWrite,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RD   = 2'd1;
   localparam logic [1:0] S_WR   = 2'd2;
   localparam logic [1:0] S_RESP = 2'd3;

   logic [1:0]        state;
   logic [ADDR_W-1:0] addr_q;
   logic              we_q;
   logic [2:0]        f3_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] old_q;

   logic              req_legal;
   logic [7:0]        lane_byte;
   logic [15:0]       lane_half;
   logic [DATA_W-1:0] load_data;
   logic [DATA_W-1:0] merge_data;

   assign req_ready  = (state == S_IDLE);
   assign resp_valid = (state == S_RESP);
   assign MemRead    = (state == S_RD);
   assign MemWrite   = (state == S_WR);
   assign mem_addr   = {addr_q[ADDR_W-1:2], 2'b00};

   always_comb begin
      req_legal = 1'b0;
      case (req_funct3)
         3'd0:    req_legal = 1'b1;
         3'd1:    req_legal = ~req_addr[0];
         3'd2:    req_legal = (req_addr[1:0] == 2'b00);
         3'd4:    req_legal = ~req_we;
         3'd5:    req_legal = ~req_we & ~req_addr[0];
         default: req_legal = 1'b0;
      endcase
   end

   always_comb begin
      lane_byte = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
      lane_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (f3_q)
         3'd0:    load_data = {{24{lane_byte[7]}}, lane_byte};
         3'd1:    load_data = {{16{lane_half[15]}}, lane_half};
         3'd4:    load_data = {24'd0, lane_byte};
         3'd5:    load_data = {16'd0, lane_half};
         default: load_data = mem_rdata;
      endcase
   end

   // Sub-word stores splice the new lane into the word captured during RD.
   always_comb begin
      merge_data = old_q;
      if (f3_q[1:0] == 2'b00)
         merge_data[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      else if (f3_q[1:0] == 2'b01)
         merge_data[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
   end

   assign mem_wdata = (f3_q[1:0] == 2'b10) ? wdata_q : merge_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         addr_q     <= '0;
         we_q       <= 1'b0;
         f3_q       <= 3'd0;
         wdata_q    <= '0;
         old_q      <= '0;
         resp_rdata <= '0;
         resp_err   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  addr_q  <= req_addr;
                  we_q    <= req_we;
                  f3_q    <= req_funct3;
                  wdata_q <= req_wdata;
                  if (!req_legal) begin
                     resp_rdata <= '0;
                     resp_err   <= 1'b1;
                     state      <= S_RESP;
                  end else if (req_we && req_funct3[1:0] == 2'b10) begin
                     state <= S_WR;
                  end else begin
                     state <= S_RD;
                  end
               end
            end
            S_RD: begin
               if (we_q) begin
                  old_q <= mem_rdata;
                  state <= S_WR;
               end else begin
                  resp_rdata <= load_data;
                  resp_err   <= 1'b0;
                  state      <= S_RESP;
               end
            end
            S_WR: begin
               resp_rdata <= '0;
               resp_err   <= 1'b0;
               state      <= S_RESP;
            end
            S_RESP:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_lsu_subword_ctrl.sv
`default_nettype none
// Bench for lsu_subword_ctrl: directed requests against a word RAM model,
// expected responses queued at issue time and checked by a monitor.
module tb_lsu_subword_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready, req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_err;
   logic [31:0] resp_rdata;
   logic        MemRead, MemWrite;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   always #5 clk = ~clk;

   lsu_subword_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .MemRead(MemRead), .MemWrite(MemWrite),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   logic [31:0] mem [0:63];
   logic        pl_en = 1'b0;
   logic [5:0]  pl_idx = '0;
   logic [31:0] pl_data = '0;

   assign mem_rdata = mem[mem_addr[7:2]];

   always @(posedge clk) begin
      if (pl_en) mem[pl_idx] <= pl_data;
      else if (MemWrite) mem[mem_addr[7:2]] <= mem_wdata;
   end

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          cyc;
      int          nrd;
      int          nwr;
   } exp_t;

   exp_t q[$];
   exp_t me;
   int   cyc = 0;
   int   total = 0;
   int   passed = 0;
   int   rd_cnt = 0;
   int   wr_cnt = 0;
   int   acc_cnt = 0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rst_n && req_valid && req_ready) acc_cnt <= acc_cnt + 1;
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, got, exp);
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         rd_cnt = 0;
         wr_cnt = 0;
      end else begin
         if (MemRead)  rd_cnt++;
         if (MemWrite) wr_cnt++;
         if (resp_valid) begin
            if (q.size() == 0) begin
               total++;
               $display("FAIL resp_unexpected: got resp_valid=1 expected no response");
            end else begin
               me = q.pop_front();
               chk("resp_rdata", resp_rdata, me.rdata);
               chk("resp_err", {31'd0, resp_err}, {31'd0, me.err});
               chk("resp_cycle", cyc, me.cyc);
               chk("memread_cycles", rd_cnt, me.nrd);
               chk("memwrite_cycles", wr_cnt, me.nwr);
               chk("ready_in_resp", {31'd0, req_ready}, 32'd0);
            end
            rd_cnt = 0;
            wr_cnt = 0;
         end
      end
   end

   task automatic preload(input int idx, input logic [31:0] d);
      pl_en = 1'b1; pl_idx = idx[5:0]; pl_data = d;
      @(posedge clk);
      @(negedge clk);
      pl_en = 1'b0;
   endtask

   // Called at a negedge; leaves req_valid asserted so back-to-back calls hold it high.
   task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] erd, input logic eerr,
                        input int lat, input int nrd, input int nwr);
      int guard = 0;
      req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
      while (!req_ready && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      if (!req_ready) begin
         total++;
         $display("FAIL accept_timeout: got req_ready=0 for 20 cycles expected 1");
      end else begin
         q.push_back('{erd, eerr, cyc + lat, nrd, nwr});
         @(posedge clk);
      end
      @(negedge clk);
   endtask

   task automatic drain;
      int guard = 0;
      req_valid = 1'b0;
      while (q.size() != 0 && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      if (q.size() != 0) begin
         total++;
         $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
         q.delete();
      end
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
      req_addr = '0; req_wdata = '0;
      @(negedge clk);
      preload(4, 32'h8081_7F02);
      preload(8, 32'h1122_3344);
      preload(9, 32'h0000_0000);
      preload(10, 32'hCAFE_F00D);
      chk("rst_ready", {31'd0, req_ready}, 32'd1);
      chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      chk("rst_rdata", resp_rdata, 32'd0);
      chk("rst_err", {31'd0, resp_err}, 32'd0);
      chk("rst_strobes", {30'd0, MemRead, MemWrite}, 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_mem_wdata", mem_wdata, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // load lanes and extension
      issue(0, 3'd0, 32'h11, 0, 32'h0000_007F, 0, 2, 1, 0); drain();
      issue(0, 3'd0, 32'h13, 0, 32'hFFFF_FF80, 0, 2, 1, 0); drain();
      issue(0, 3'd4, 32'h13, 0, 32'h0000_0080, 0, 2, 1, 0); drain();
      issue(0, 3'd1, 32'h12, 0, 32'hFFFF_8081, 0, 2, 1, 0); drain();
      issue(0, 3'd5, 32'h10, 0, 32'h0000_7F02, 0, 2, 1, 0); drain();
      issue(0, 3'd2, 32'h10, 0, 32'h8081_7F02, 0, 2, 1, 0); drain();

      // sub-word read-modify-write and word store
      issue(1, 3'd0, 32'h21, 32'h0000_00AB, 0, 0, 3, 1, 1); drain();
      chk("mem_after_sb", mem[8], 32'h1122_AB44);
      issue(1, 3'd1, 32'h22, 32'h0000_BEEF, 0, 0, 3, 1, 1); drain();
      chk("mem_after_sh", mem[8], 32'hBEEF_AB44);
      issue(0, 3'd2, 32'h20, 0, 32'hBEEF_AB44, 0, 2, 1, 0); drain();
      issue(1, 3'd2, 32'h24, 32'hDEAD_BEEF, 0, 0, 2, 0, 1); drain();
      chk("mem_after_sw", mem[9], 32'hDEAD_BEEF);
      issue(0, 3'd2, 32'h24, 0, 32'hDEAD_BEEF, 0, 2, 1, 0); drain();

      // errors: misaligned half load, misaligned word store, illegal funct3
      issue(0, 3'd1, 32'h31, 0, 0, 1, 1, 0, 0); drain();
      issue(1, 3'd2, 32'h32, 32'h1234_5678, 0, 1, 1, 0, 0); drain();
      issue(0, 3'd3, 32'h10, 0, 0, 1, 1, 0, 0); drain();

      // back-to-back loads with req_valid never dropping
      issue(0, 3'd2, 32'h10, 0, 32'h8081_7F02, 0, 2, 1, 0);
      issue(0, 3'd2, 32'h20, 0, 32'hBEEF_AB44, 0, 2, 1, 0);
      issue(0, 3'd2, 32'h24, 0, 32'hDEAD_BEEF, 0, 2, 1, 0);
      drain();

      // async reset while an SB sits in RD
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd0;
      req_addr = 32'h28; req_wdata = 32'h55;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      chk("sb_in_rd", {31'd0, MemRead}, 32'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("rst_async_strobes", {30'd0, MemRead, MemWrite}, 32'd0);
      chk("rst_async_ready", {31'd0, req_ready}, 32'd1);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("mem_after_abort", mem[10], 32'hCAFE_F00D);
      issue(0, 3'd2, 32'h28, 0, 32'hCAFE_F00D, 0, 2, 1, 0); drain();

      chk("accept_count", acc_cnt, 32'd19);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
`default_nettype wire
